// File: rtl/sfp_send_32to8_if.sv
// Word-side and byte-side handshake signals of the SFP 32-to-8 transmit path.
// master = word source / byte sink (scheduler + MAC), slave = the serialiser.
// tx_ack travels back to the word source; the byte stream is strobe-only (no backpressure).
interface sfp_send_32to8_if;
  logic [32:0] data_in;
  logic        data_in_valid;
  logic        tx_ack;
  logic [7:0]  data_out_sfp;
  logic        data_out_sfp_valid;

  modport master (
    output data_in, data_in_valid,
    input  tx_ack, data_out_sfp, data_out_sfp_valid
  );

  modport slave (
    input  data_in, data_in_valid,
    output tx_ack, data_out_sfp, data_out_sfp_valid
  );
endinterface

// File: rtl/sfp_send_32to8.sv
// Buffers one 33-bit word packet, validates header/SFP number, serialises IP, port, payload MSB-first as bytes.
// Latency: first byte 2 clk after the cycle data_in_valid drops; frame is contiguous, then IFG_CYCLES idle.
// No backpressure on bytes; the word side is paced by a tx_ack pulse issued once the previous frame+gap is done.
module sfp_send_32to8 #(
  parameter logic [7:0] SFP_OUT_NUM = 8'd1,
  parameter int         MAX_WORDS   = 50,
  parameter int         IFG_CYCLES  = 12
) (
  input  logic              clk,
  input  logic              reset,
  sfp_send_32to8_if.slave   bus,
  output logic [15:0]       drop_cnt,
  output logic              ovf_flag
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int IW = $clog2(MAX_WORDS);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam logic [CW-1:0] MAX_W    = CW'(MAX_WORDS);
  localparam logic [CW-1:0] MIN_W    = CW'(3);
  localparam logic [GW-1:0] LAST_GAP = GW'(IFG_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ACK, ST_WAIT, ST_RECV, ST_CHECK,
    ST_SEND_IP, ST_SEND_PORT, ST_SEND_DATA, ST_GAP
  } state_t;

  state_t         state, state_nxt;
  logic [32:0]    mem [MAX_WORDS];
  logic [CW-1:0]  wr_cnt;
  logic [CW-1:0]  rd_idx;
  logic [1:0]     byte_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           mark_err;
  logic           drop_pkt;
  logic           wr_en;
  logic [IW-1:0]  wr_addr;
  logic [IW-1:0]  rd_sel;
  logic           sending;
  logic           last_word;
  logic [7:0]     send_byte;

  // Header must carry the marker and our SFP number, at least header+IP+port, no stray header markers later.
  assign drop_pkt = !mem[0][32] || (mem[0][7:0] != SFP_OUT_NUM) || (wr_cnt < MIN_W) || mark_err;

  // Words past MAX_WORDS are never written; the stored packet is simply truncated.
  assign wr_en   = bus.data_in_valid && ((state == ST_WAIT) || ((state == ST_RECV) && (wr_cnt < MAX_W)));
  assign wr_addr = (state == ST_WAIT) ? '0 : wr_cnt[IW-1:0];

  assign rd_sel    = rd_idx[IW-1:0];
  assign last_word = (rd_idx == wr_cnt - CW'(1));
  assign sending   = (state == ST_SEND_IP) || (state == ST_SEND_PORT) || (state == ST_SEND_DATA);

  assign bus.tx_ack             = (state == ST_ACK);
  assign bus.data_out_sfp_valid = sending;
  assign bus.data_out_sfp       = sending ? send_byte : 8'h00;

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one packet in flight, ack only after the previous frame and gap.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      state_nxt = ST_ACK;
      ST_ACK:       state_nxt = ST_WAIT;
      ST_WAIT:      if (bus.data_in_valid) state_nxt = ST_RECV;
      ST_RECV:      if (!bus.data_in_valid) state_nxt = ST_CHECK;
      ST_CHECK:     state_nxt = drop_pkt ? ST_GAP : ST_SEND_IP;
      ST_SEND_IP:   if (byte_cnt == 2'd3) state_nxt = ST_SEND_PORT;
      ST_SEND_PORT: if (byte_cnt == 2'd3) state_nxt = (wr_cnt == MIN_W) ? ST_GAP : ST_SEND_DATA;
      ST_SEND_DATA: if ((byte_cnt == 2'd3) && last_word) state_nxt = ST_GAP;
      ST_GAP:       if (gap_cnt == LAST_GAP) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Byte select within the word currently being serialised, MSB first.
  always_comb begin
    send_byte = 8'h00;
    case (byte_cnt)
      2'd0: send_byte = mem[rd_sel][31:24];
      2'd1: send_byte = mem[rd_sel][23:16];
      2'd2: send_byte = mem[rd_sel][15:8];
      2'd3: send_byte = mem[rd_sel][7:0];
      default: send_byte = 8'h00;
    endcase
  end

  // Packet buffer; contents are only meaningful up to wr_cnt, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.data_in;
  end

  // Write/read indices, byte and gap counters, drop and overflow bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt   <= '0;
      rd_idx   <= '0;
      byte_cnt <= 2'd0;
      gap_cnt  <= '0;
      mark_err <= 1'b0;
      drop_cnt <= 16'h0000;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_cnt   <= '0;
          rd_idx   <= '0;
          byte_cnt <= 2'd0;
          gap_cnt  <= '0;
          mark_err <= 1'b0;
        end
        ST_WAIT: begin
          if (bus.data_in_valid) wr_cnt <= CW'(1);
        end
        ST_RECV: begin
          if (bus.data_in_valid) begin
            if (wr_cnt < MAX_W) begin
              wr_cnt <= wr_cnt + CW'(1);
              if (bus.data_in[32]) mark_err <= 1'b1;
            end else begin
              ovf_flag <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          rd_idx   <= CW'(1);
          byte_cnt <= 2'd0;
          gap_cnt  <= '0;
          if (drop_pkt && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
        ST_SEND_IP: begin
          // Port goes out as its low two bytes only, so start that word at byte 2.
          if (byte_cnt == 2'd3) begin
            rd_idx   <= CW'(2);
            byte_cnt <= 2'd2;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        ST_SEND_PORT: begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) rd_idx <= CW'(3);
        end
        ST_SEND_DATA: begin
          byte_cnt <= byte_cnt + 2'd1;
          if ((byte_cnt == 2'd3) && !last_word) rd_idx <= rd_idx + CW'(1);
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
